// File: rtl/mips_pkg.sv
// Shared MIPS datapath types for the multiply/divide unit.
package mips_pkg;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_t;

  typedef enum logic [1:0] {
    MD_IDLE,
    MD_PREP,
    MD_CALC,
    MD_FIX
  } md_state_t;

  localparam int MD_WIDTH_DEFAULT = 32;

  // True for the two divide opcodes; multiplies share the shift-add path.
  function automatic logic op_is_div(input md_op_t op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  // True for the signed opcodes, which run on magnitudes and fix signs at the end.
  function automatic logic op_is_signed(input md_op_t op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

endpackage

// File: rtl/md_step.sv
// One radix-2 iteration of the multiply/divide unit, purely combinational.
// Multiply: acc = {partial product, remaining multiplier bits}, shift-add.
// Divide:   acc = {partial remainder, quotient bits}, restoring step.
module md_step
  import mips_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH_DEFAULT
) (
  input  md_op_t             mode,
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   operand,
  output logic [2*WIDTH-1:0] next_acc
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] diff;

  // Compute both candidate steps and pick the one matching the mode.
  always_comb begin
    sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, operand};
    rem_sh   = acc[2*WIDTH-1:WIDTH-1];
    diff     = rem_sh[WIDTH-1:0] - operand;
    next_acc = '0;
    if (op_is_div(mode)) begin
      if (rem_sh >= {1'b0, operand}) begin
        next_acc = {diff, acc[WIDTH-2:0], 1'b1};
      end else begin
        next_acc = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      end
    end else if (acc[0]) begin
      next_acc = {sum, acc[WIDTH-1:1]};
    end else begin
      next_acc = {1'b0, acc[2*WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Signed operations run on magnitudes; signs are restored when HI/LO are
// written on entry to FIX, so done and the new HI/LO appear in the same cycle.
module mult_div_unit
  import mips_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH_DEFAULT
) (
  input  logic             Clk,
  input  logic             reset,
  input  logic             start,
  input  md_op_t           op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  md_state_t          state;
  md_op_t             op_r;
  logic [WIDTH-1:0]   rs_r;
  logic [WIDTH-1:0]   rt_r;
  logic [WIDTH-1:0]   operand;
  logic [2*WIDTH-1:0] acc;
  logic [CNT_W-1:0]   cnt;
  logic               neg_q;
  logic               neg_r;

  logic               is_div;
  logic               is_signed;
  logic [WIDTH-1:0]   abs_rs;
  logic [WIDTH-1:0]   abs_rt;
  logic [2*WIDTH-1:0] step_acc;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   fix_hi;
  logic [WIDTH-1:0]   fix_lo;

  md_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .mode    (op_r),
    .acc     (acc),
    .operand (operand),
    .next_acc(step_acc)
  );

  // Operand magnitudes and the sign-corrected final result of the last step.
  always_comb begin
    is_div    = op_is_div(op_r);
    is_signed = op_is_signed(op_r);
    abs_rs    = (is_signed && rs_r[WIDTH-1]) ? -rs_r : rs_r;
    abs_rt    = (is_signed && rt_r[WIDTH-1]) ? -rt_r : rt_r;
    prod      = neg_q ? -step_acc : step_acc;
    fix_hi    = prod[2*WIDTH-1:WIDTH];
    fix_lo    = prod[WIDTH-1:0];
    if (is_div) begin
      fix_lo = neg_q ? -step_acc[WIDTH-1:0] : step_acc[WIDTH-1:0];
      fix_hi = neg_r ? -step_acc[2*WIDTH-1:WIDTH] : step_acc[2*WIDTH-1:WIDTH];
    end
  end

  // Control FSM, iteration datapath and HI/LO registers.
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      state       <= MD_IDLE;
      op_r        <= MD_MULT;
      rs_r        <= '0;
      rt_r        <= '0;
      operand     <= '0;
      acc         <= '0;
      cnt         <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      hi          <= '0;
      lo          <= '0;
    end else begin
      case (state)
        MD_IDLE: begin
          done        <= 1'b0;
          div_by_zero <= 1'b0;
          if (hi_we) hi <= wdata;
          if (lo_we) lo <= wdata;
          if (start) begin
            op_r  <= op;
            rs_r  <= rs_val;
            rt_r  <= rt_val;
            busy  <= 1'b1;
            state <= MD_PREP;
          end
        end
        MD_PREP: begin
          neg_q <= is_signed & (rs_r[WIDTH-1] ^ rt_r[WIDTH-1]);
          neg_r <= is_signed & rs_r[WIDTH-1];
          cnt   <= CNT_W'(WIDTH);
          if (is_div) begin
            acc     <= {{WIDTH{1'b0}}, abs_rs};
            operand <= abs_rt;
            if (rt_r == '0) begin
              hi          <= rs_r;
              lo          <= '1;
              done        <= 1'b1;
              div_by_zero <= 1'b1;
              state       <= MD_FIX;
            end else begin
              state <= MD_CALC;
            end
          end else begin
            acc     <= {{WIDTH{1'b0}}, abs_rt};
            operand <= abs_rs;
            state   <= MD_CALC;
          end
        end
        MD_CALC: begin
          acc <= step_acc;
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) begin
            hi    <= fix_hi;
            lo    <= fix_lo;
            done  <= 1'b1;
            state <= MD_FIX;
          end
        end
        MD_FIX: begin
          done        <= 1'b0;
          div_by_zero <= 1'b0;
          busy        <= 1'b0;
          state       <= MD_IDLE;
        end
        default: state <= MD_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: a 32-bit instance and an 8-bit instance.
// Inputs change 1ns after the rising edge; outputs are sampled there too.
module tb_mult_div_unit;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;

  logic        start = 1'b0;
  md_op_t      op = MD_MULT;
  logic [31:0] rs_val = '0;
  logic [31:0] rt_val = '0;
  logic        hi_we = 1'b0;
  logic        lo_we = 1'b0;
  logic [31:0] wdata = '0;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;

  logic        start8 = 1'b0;
  md_op_t      op8 = MD_MULT;
  logic [7:0]  rs8 = '0;
  logic [7:0]  rt8 = '0;
  logic        hi_we8 = 1'b0;
  logic        lo_we8 = 1'b0;
  logic [7:0]  wdata8 = '0;
  logic        busy8, done8, dz8;
  logic [7:0]  hi8, lo8;

  int n_compared = 0;
  int n_mismatched = 0;

  mult_div_unit #(.WIDTH(32)) dut (
    .Clk(clk), .reset(reset), .start(start), .op(op),
    .rs_val(rs_val), .rt_val(rt_val), .hi_we(hi_we), .lo_we(lo_we),
    .wdata(wdata), .busy(busy), .done(done), .div_by_zero(div_by_zero),
    .hi(hi), .lo(lo)
  );

  mult_div_unit #(.WIDTH(8)) dut8 (
    .Clk(clk), .reset(reset), .start(start8), .op(op8),
    .rs_val(rs8), .rt_val(rt8), .hi_we(hi_we8), .lo_we(lo_we8),
    .wdata(wdata8), .busy(busy8), .done(done8), .div_by_zero(dz8),
    .hi(hi8), .lo(lo8)
  );

  // Free-running 100 MHz clock.
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Moves to an IDLE cycle, holds start for one edge, then scrambles operands.
  task automatic launch(input md_op_t o, input logic [31:0] a, input logic [31:0] b);
    tick();
    op = o; rs_val = a; rt_val = b; start = 1'b1;
    tick();
    start = 1'b0; rs_val = 32'hA5A5_A5A5; rt_val = 32'h5A5A_5A5A;
  endtask

  // Returns the cycle (1 = first after start) in which done is seen, 0 on timeout.
  task automatic wait_done(output int lat);
    lat = 1;
    while (done !== 1'b1 && lat < 100) begin
      tick();
      lat++;
    end
    if (done !== 1'b1) lat = 0;
  endtask

  task automatic test_reset();
    #12;
    n_compared++; if (busy !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    n_compared++; if (done !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
    n_compared++; if (div_by_zero !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_dz: got %b expected 0", div_by_zero); end
    n_compared++; if (hi !== 32'h0) begin n_mismatched++; $display("[TB] FAIL reset_hi: got %h expected 00000000", hi); end
    n_compared++; if (lo !== 32'h0) begin n_mismatched++; $display("[TB] FAIL reset_lo: got %h expected 00000000", lo); end
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_multu_latency();
    logic exp_busy, exp_done;
    launch(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    for (int k = 1; k <= 36; k++) begin
      exp_busy = (k <= 34);
      exp_done = (k == 34);
      n_compared++; if (busy !== exp_busy) begin n_mismatched++; $display("[TB] FAIL multu_busy_c%0d: got %b expected %b", k, busy, exp_busy); end
      n_compared++; if (done !== exp_done) begin n_mismatched++; $display("[TB] FAIL multu_done_c%0d: got %b expected %b", k, done, exp_done); end
      if (k == 34) begin
        n_compared++; if (hi !== 32'hFFFF_FFFE) begin n_mismatched++; $display("[TB] FAIL multu_hi: got %h expected fffffffe", hi); end
        n_compared++; if (lo !== 32'h0000_0001) begin n_mismatched++; $display("[TB] FAIL multu_lo: got %h expected 00000001", lo); end
        n_compared++; if (div_by_zero !== 1'b0) begin n_mismatched++; $display("[TB] FAIL multu_dz: got %b expected 0", div_by_zero); end
      end
      tick();
    end
  endtask

  task automatic test_signed();
    int lat;
    launch(MD_MULT, 32'hFFFF_FFFD, 32'h0000_0005);
    wait_done(lat);
    n_compared++; if (lat != 34) begin n_mismatched++; $display("[TB] FAIL mult_latency: got %0d expected 34", lat); end
    n_compared++; if (hi !== 32'hFFFF_FFFF) begin n_mismatched++; $display("[TB] FAIL mult_hi: got %h expected ffffffff", hi); end
    n_compared++; if (lo !== 32'hFFFF_FFF1) begin n_mismatched++; $display("[TB] FAIL mult_lo: got %h expected fffffff1", lo); end
    launch(MD_DIV, 32'hFFFF_FFF9, 32'h0000_0002);
    wait_done(lat);
    n_compared++; if (lat != 34) begin n_mismatched++; $display("[TB] FAIL div_latency: got %0d expected 34", lat); end
    n_compared++; if (lo !== 32'hFFFF_FFFD) begin n_mismatched++; $display("[TB] FAIL div_lo: got %h expected fffffffd", lo); end
    n_compared++; if (hi !== 32'hFFFF_FFFF) begin n_mismatched++; $display("[TB] FAIL div_hi: got %h expected ffffffff", hi); end
  endtask

  task automatic test_div_edges();
    int lat;
    launch(MD_DIVU, 32'h0000_0007, 32'h0000_0000);
    wait_done(lat);
    n_compared++; if (lat != 2) begin n_mismatched++; $display("[TB] FAIL dz_latency: got %0d expected 2", lat); end
    n_compared++; if (div_by_zero !== 1'b1) begin n_mismatched++; $display("[TB] FAIL dz_flag: got %b expected 1", div_by_zero); end
    n_compared++; if (hi !== 32'h0000_0007) begin n_mismatched++; $display("[TB] FAIL dz_hi: got %h expected 00000007", hi); end
    n_compared++; if (lo !== 32'hFFFF_FFFF) begin n_mismatched++; $display("[TB] FAIL dz_lo: got %h expected ffffffff", lo); end
    tick();
    n_compared++; if (div_by_zero !== 1'b0) begin n_mismatched++; $display("[TB] FAIL dz_pulse_end: got %b expected 0", div_by_zero); end
    n_compared++; if (done !== 1'b0) begin n_mismatched++; $display("[TB] FAIL dz_done_end: got %b expected 0", done); end
    launch(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(lat);
    n_compared++; if (lat != 34) begin n_mismatched++; $display("[TB] FAIL minneg_latency: got %0d expected 34", lat); end
    n_compared++; if (lo !== 32'h8000_0000) begin n_mismatched++; $display("[TB] FAIL minneg_lo: got %h expected 80000000", lo); end
    n_compared++; if (hi !== 32'h0000_0000) begin n_mismatched++; $display("[TB] FAIL minneg_hi: got %h expected 00000000", hi); end
    n_compared++; if (div_by_zero !== 1'b0) begin n_mismatched++; $display("[TB] FAIL minneg_dz: got %b expected 0", div_by_zero); end
  endtask

  task automatic test_start_while_busy();
    int done_count, done_k;
    logic [31:0] hi_at_done, lo_at_done;
    tick();
    hi_we = 1'b1; wdata = 32'h0000_0055;
    tick();
    hi_we = 1'b0;
    n_compared++; if (hi !== 32'h0000_0055) begin n_mismatched++; $display("[TB] FAIL mthi_idle: got %h expected 00000055", hi); end
    launch(MD_MULTU, 32'd3, 32'd4);
    done_count = 0; done_k = 0; hi_at_done = '0; lo_at_done = '0;
    for (int k = 1; k <= 45; k++) begin
      start = (k == 10);
      if (k == 10) begin op = MD_MULT; rs_val = 32'd5; rt_val = 32'd6; end
      hi_we = (k == 12);
      wdata = 32'hDEAD_BEEF;
      if (k == 14) begin
        n_compared++; if (hi !== 32'h0000_0055) begin n_mismatched++; $display("[TB] FAIL hi_hold_busy: got %h expected 00000055", hi); end
      end
      if (done === 1'b1) begin
        done_count++; done_k = k; hi_at_done = hi; lo_at_done = lo;
      end
      tick();
    end
    start = 1'b0; hi_we = 1'b0;
    n_compared++; if (done_count != 1) begin n_mismatched++; $display("[TB] FAIL busy_done_count: got %0d expected 1", done_count); end
    n_compared++; if (done_k != 34) begin n_mismatched++; $display("[TB] FAIL busy_done_cycle: got %0d expected 34", done_k); end
    n_compared++; if (hi_at_done !== 32'h0) begin n_mismatched++; $display("[TB] FAIL busy_hi: got %h expected 00000000", hi_at_done); end
    n_compared++; if (lo_at_done !== 32'd12) begin n_mismatched++; $display("[TB] FAIL busy_lo: got %h expected 0000000c", lo_at_done); end
    n_compared++; if (hi !== 32'h0) begin n_mismatched++; $display("[TB] FAIL busy_hi_after: got %h expected 00000000", hi); end
  endtask

  task automatic test_mt_and_async_reset();
    int lat;
    tick();
    lo_we = 1'b1; wdata = 32'h0000_1234;
    tick();
    lo_we = 1'b0;
    n_compared++; if (lo !== 32'h0000_1234) begin n_mismatched++; $display("[TB] FAIL mtlo: got %h expected 00001234", lo); end
    n_compared++; if (hi !== 32'h0) begin n_mismatched++; $display("[TB] FAIL mtlo_hi_kept: got %h expected 00000000", hi); end
    hi_we = 1'b1; wdata = 32'h0000_5678;
    tick();
    hi_we = 1'b0;
    n_compared++; if (hi !== 32'h0000_5678) begin n_mismatched++; $display("[TB] FAIL mthi: got %h expected 00005678", hi); end
    launch(MD_DIV, 32'd100, 32'd7);
    repeat (10) tick();
    #3 reset = 1'b1;
    #1;
    n_compared++; if (busy !== 1'b0) begin n_mismatched++; $display("[TB] FAIL areset_busy: got %b expected 0", busy); end
    n_compared++; if (done !== 1'b0) begin n_mismatched++; $display("[TB] FAIL areset_done: got %b expected 0", done); end
    n_compared++; if (hi !== 32'h0) begin n_mismatched++; $display("[TB] FAIL areset_hi: got %h expected 00000000", hi); end
    n_compared++; if (lo !== 32'h0) begin n_mismatched++; $display("[TB] FAIL areset_lo: got %h expected 00000000", lo); end
    @(posedge clk);
    #1 reset = 1'b0;
    launch(MD_DIV, 32'd100, 32'd7);
    wait_done(lat);
    n_compared++; if (lat != 34) begin n_mismatched++; $display("[TB] FAIL post_reset_latency: got %0d expected 34", lat); end
    n_compared++; if (lo !== 32'd14) begin n_mismatched++; $display("[TB] FAIL post_reset_lo: got %h expected 0000000e", lo); end
    n_compared++; if (hi !== 32'd2) begin n_mismatched++; $display("[TB] FAIL post_reset_hi: got %h expected 00000002", hi); end
  endtask

  task automatic test_width8();
    int lat;
    tick();
    op8 = MD_MULT; rs8 = 8'h80; rt8 = 8'h80; start8 = 1'b1;
    tick();
    start8 = 1'b0; rs8 = 8'h3C; rt8 = 8'hC3;
    lat = 1;
    while (done8 !== 1'b1 && lat < 50) begin tick(); lat++; end
    n_compared++; if (lat != 10) begin n_mismatched++; $display("[TB] FAIL w8_mult_latency: got %0d expected 10", lat); end
    n_compared++; if (hi8 !== 8'h40) begin n_mismatched++; $display("[TB] FAIL w8_mult_hi: got %h expected 40", hi8); end
    n_compared++; if (lo8 !== 8'h00) begin n_mismatched++; $display("[TB] FAIL w8_mult_lo: got %h expected 00", lo8); end
    tick();
    op8 = MD_DIVU; rs8 = 8'hFF; rt8 = 8'h10; start8 = 1'b1;
    tick();
    start8 = 1'b0; rs8 = 8'h00; rt8 = 8'h00;
    lat = 1;
    while (done8 !== 1'b1 && lat < 50) begin tick(); lat++; end
    n_compared++; if (lat != 10) begin n_mismatched++; $display("[TB] FAIL w8_divu_latency: got %0d expected 10", lat); end
    n_compared++; if (lo8 !== 8'h0F) begin n_mismatched++; $display("[TB] FAIL w8_divu_lo: got %h expected 0f", lo8); end
    n_compared++; if (hi8 !== 8'h0F) begin n_mismatched++; $display("[TB] FAIL w8_divu_hi: got %h expected 0f", hi8); end
  endtask

  // Runs every scenario in order and prints the summary.
  initial begin
    test_reset();
    test_multu_latency();
    test_signed();
    test_div_edges();
    test_start_while_busy();
    test_mt_and_async_reset();
    test_width8();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

  // Guards against a hang if done never arrives.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
Parametrised iterative multiply/divide unit with architectural HI/LO registers. It executes MULT, MULTU, DIV and DIVU for the multicycle MIPS datapath. Operands come from the A/B register outputs; the control FSM starts the unit and stalls on busy until done. HI/LO feed the MFHI/MFLO write-back path and accept MTHI/MTLO writes.

Parameters:
WIDTH, 32, operand width; HI and LO are each WIDTH bits (WIDTH >= 4, even)
CNT_W, $clog2(WIDTH+1), iteration counter width (derived; do not override)

Ports:
Clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high; clears all state
start  in  1  launch request; sampled only in IDLE
op  in  2  md_op_t: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
rs_val  in  WIDTH  multiplicand / dividend
rt_val  in  WIDTH  multiplier / divisor
hi_we  in  1  MTHI write strobe
lo_we  in  1  MTLO write strobe
wdata  in  WIDTH  MTHI/MTLO data
busy  out  1  high from the cycle after start is accepted until the done cycle, inclusive
done  out  1  one-cycle pulse; HI/LO hold the result in that same cycle
div_by_zero  out  1  one-cycle pulse coincident with done when a DIV/DIVU had rt_val==0
hi  out  WIDTH  HI register
lo  out  WIDTH  LO register

Behaviour:
- Reset (async, any state): state=IDLE; hi, lo, busy, done, div_by_zero, counter and all internal registers = 0.
- FSM states: IDLE, PREP, CALC, FIX.
- IDLE: start=1 latches op, rs_val and rt_val; next state is PREP. Otherwise the FSM stays in IDLE.
- PREP (1 cycle): for signed ops, form absolute values and record the result signs (quotient/product sign = sign(rs)^sign(rt); remainder sign = sign(rs)). Load counter=WIDTH.
- PREP, divide op with rt==0: skip to FIX with the dz flag set.
- CALC (WIDTH cycles): one radix-2 step per cycle.
  - Multiply: shift-add into a 2*WIDTH accumulator.
  - Divide: restoring step on a {rem, quot} pair.
  - The counter decrements each cycle; on counter==1 the next state is FIX.
- FIX (1 cycle):
  - Apply two's-complement sign correction and write HI/LO (mult: HI=upper, LO=lower; div: LO=quotient, HI=remainder).
  - Assert done; return to IDLE.
- Latency: start sampled at edge N gives done high during cycle N+WIDTH+2 (34 for WIDTH=32). Divide-by-zero gives done at N+2.
- Divide by zero: HI=rs_val, LO=all ones, div_by_zero pulses; no trap is raised here.
- DIV of the most-negative value by -1: LO=most-negative value, HI=0. This follows naturally from the magnitude path; no special case is needed.
- Remainder sign follows the dividend; quotient truncates toward zero.
- start while busy (PREP/CALC/FIX): ignored and not queued.
- hi_we/lo_we:
  - In IDLE: the register is written with wdata at the edge.
  - Together with start in IDLE: the write is applied, and the operation result later overwrites it.
  - While busy: ignored. The control FSM must stall MTHI/MTLO until done.
- HI/LO change only on reset, an accepted MT write, or FIX. They are stable throughout PREP/CALC, so MFHI during busy returns the old values.
- Operand inputs are don't-care after the start cycle.

Decomposition:
- Shared package mips_pkg holds:
  - typedef enum logic [1:0] md_op_t {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU};
  - typedef enum logic [1:0] md_state_t {MD_IDLE, MD_PREP, MD_CALC, MD_FIX};
  - localparam MD_WIDTH_DEFAULT = 32.
- One sub-module: md_step, purely combinational, one iteration.
  - Inputs: mode, accumulator, operand.
  - Outputs: next accumulator.
- The FSM, counter and HI/LO registers stay in mult_div_unit.

Test Plan:
1. MULTU rs=0xFFFFFFFF rt=0xFFFFFFFF -> done exactly 34 cycles after start; hi=0xFFFFFFFE, lo=0x00000001; busy high cycles 1..34.
2. MULT rs=0xFFFFFFFD(-3) rt=0x00000005 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1; DIV rs=0xFFFFFFF9(-7) rt=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
3. DIVU rs=7 rt=0 -> done and div_by_zero together 2 cycles after start; hi=0x00000007, lo=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0, no div_by_zero.
4. Start MULTU 3*4, then pulse start with new operands at cycle 10 and hi_we at cycle 12 -> both ignored; result hi=0, lo=12; a single done pulse.
5. In IDLE: lo_we with wdata=0x1234 -> lo=0x1234 next cycle. Then assert reset asynchronously mid-CALC of a DIV -> busy, done, hi and lo all 0 immediately. After release, a new start completes normally.
6. WIDTH=8 instance: MULT 0x80*0x80 -> hi=0x40, lo=0x00, done after 10 cycles; DIVU 0xFF/0x10 -> lo=0x0F, hi=0x0F.
